// File: rtl/hilo_mult_unit.sv
// Multi-cycle radix-2 shift-add multiplier (MULT/MULTU) owning the HI/LO pair.
// Optional macro EARLY_TERM_EN: leave RUN once the remaining multiplier bits are all zero.
module hilo_mult_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op_signed,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             double,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   logic               neg;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [WIDTH:0]     sum;
   logic               last_step;
   logic               term;

   // Unsigned magnitude: the most negative operand maps to 2^(WIDTH-1) without overflow.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
      logic signed [WIDTH-1:0] s;
      s = v;
      return (sgn && s[WIDTH-1]) ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v, input logic n);
      return n ? (~v + 1'b1) : v;
   endfunction

   // Partial products accumulate in a WIDTH+1 window starting at bit cnt; bits above it are still zero.
   always_comb begin
      acc_nxt = acc;
      sum     = {1'b0, acc[cnt +: WIDTH]} + {1'b0, mcand};
      if (mplier[cnt])
         acc_nxt[cnt +: WIDTH+1] = sum;
   end

   assign last_step = (cnt == CW'(WIDTH-1));

`ifdef EARLY_TERM_EN
   assign term = last_step || (((mplier >> cnt) >> 1) == '0);
`else
   assign term = last_step;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         busy   <= 1'b0;
         double <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state  <= RUN;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  double <= 1'b1;
               end else begin
                  if (wr_hi) hi <= wr_data;
                  if (wr_lo) lo <= wr_data;
               end
            end
            RUN: begin
               cnt <= cnt + 1'b1;
               if (term) begin
                  state  <= FIX;
                  double <= 1'b0;
                  done   <= 1'b1;
               end
            end
            FIX: begin
               {hi, lo} <= apply_sign(acc, neg);
               state    <= IDLE;
               busy     <= 1'b0;
               done     <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy   <= 1'b0;
               double <= 1'b0;
               done   <= 1'b0;
            end
         endcase
      end
   end

   // Operand and accumulator datapath; always reloaded by start, so it carries no reset.
   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         mcand  <= magnitude(op_a, op_signed);
         mplier <= magnitude(op_b, op_signed);
         neg    <= op_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
         acc    <= '0;
      end else if (state == RUN) begin
         acc <= acc_nxt;
      end
   end

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Self-checking bench for hilo_mult_unit: directed corner cases plus randomized MULT/MULTU.
module tb_hilo_mult_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         op_signed;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         wr_hi;
   logic         wr_lo;
   logic [W-1:0] wr_data;
   logic         busy;
   logic         double;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int checks   = 0;
   int failures = 0;

   hilo_mult_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op_signed(op_signed),
      .op_a(op_a), .op_b(op_b), .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
      .busy(busy), .double(double), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference product from plain 64-bit arithmetic.
   function automatic logic [63:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
      longint sa, sb;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   // Expected number of RUN cycles.
   function automatic int ref_run_cycles(input logic [W-1:0] b, input bit sgn);
`ifdef EARLY_TERM_EN
      longint m;
      int h;
      if (sgn && b[W-1]) m = -longint'($signed(b));
      else               m = longint'({32'b0, b});
      if (m == 0) return 1;
      h = 0;
      for (int i = 0; i < 64; i++)
         if ((m >> i) != 0) h = i;
      return h + 1;
`else
      return W;
`endif
   endfunction

   task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                          input bit wr_lo_with_start, input bit disturb, input string name);
      logic [63:0]  exp;
      logic [W-1:0] hi0, lo0;
      int           k, c;
      bit           held;
      exp  = ref_product(a, b, sgn);
      k    = ref_run_cycles(b, sgn);
      hi0  = hi;
      lo0  = lo;
      held = 1'b1;
      op_a = a; op_b = b; op_signed = sgn; start = 1'b1;
      wr_lo = wr_lo_with_start; wr_data = $urandom;
      tick();
      start = 1'b0; wr_lo = 1'b0;
      op_a = $urandom; op_b = $urandom; op_signed = 1'($urandom);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL %s busy_after_start: got %b want 1", name, busy);
      end
      c = 1;
      while (done !== 1'b1 && c <= W + 4) begin
         if (double !== 1'b1 || hi !== hi0 || lo !== lo0) held = 1'b0;
         if (disturb) begin
            wr_hi = 1'b1; wr_lo = 1'($urandom); wr_data = $urandom; start = 1'($urandom);
         end
         tick();
         c++;
      end
      wr_hi = 1'b0; wr_lo = 1'b0; start = 1'b0;
      checks++;
      if (!held) begin
         failures++;
         $display("FAIL %s run_hold: hi/lo changed or double low during RUN", name);
      end
      checks++;
      if (done !== 1'b1 || c != k + 1) begin
         failures++;
         $display("FAIL %s latency: got done=%b at cycle %0d want cycle %0d", name, done, c, k + 1);
      end
      checks++;
      if (busy !== 1'b1 || double !== 1'b0 || hi !== hi0 || lo !== lo0) begin
         failures++;
         $display("FAIL %s fix_cycle: got busy=%b double=%b hi=%h lo=%h want busy=1 double=0 hi=%h lo=%h",
                  name, busy, double, hi, lo, hi0, lo0);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || {hi, lo} !== exp) begin
         failures++;
         $display("FAIL %s result: got busy=%b done=%b hi=%h lo=%h want busy=0 done=0 hi=%h lo=%h",
                  name, busy, done, hi, lo, exp[63:32], exp[31:0]);
      end
   endtask

   task automatic test_reset();
      logic [W-1:0] d1, d2;
      d1 = $urandom; d2 = $urandom;
      wr_hi = 1'b1; wr_lo = 1'b1; wr_data = d1;
      tick();
      wr_lo = 1'b0; wr_data = d2;
      tick();
      wr_hi = 1'b0;
      checks++;
      if (hi !== d2 || lo !== d1) begin
         failures++;
         $display("FAIL mthi_mtlo: got hi=%h lo=%h want hi=%h lo=%h", hi, lo, d2, d1);
      end
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      checks++;
      if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0 || double !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b double=%b want all 0",
                  hi, lo, busy, done, double);
      end
   endtask

   task automatic test_directed();
      do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "multu_max");
      do_mult(-32'sd7, 32'sd3, 1'b1, 1'b0, 1'b0, "mult_m7x3");
      do_mult(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0, "mult_minxmin");
      do_mult(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0, "mult_minx1");
      do_mult(32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 1'b0, "mult_bzero");
      do_mult(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b0, "multu_msb");
   endtask

   task automatic test_mt_priority();
      wr_hi = 1'b1; wr_data = 32'h1234_5678;
      tick();
      wr_hi = 1'b0;
      checks++;
      if (hi !== 32'h1234_5678) begin
         failures++;
         $display("FAIL mthi_write: got hi=%h want 12345678", hi);
      end
      do_mult(32'h0001_0003, 32'h0002_0005, 1'b0, 1'b1, 1'b1, "start_wins_wr");
   endtask

   task automatic test_reset_mid_run();
      op_a = $urandom; op_b = 32'hFFFF_FFFF; op_signed = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if (hi !== '0 || lo !== '0 || busy !== 1'b0 || double !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_run: got hi=%h lo=%h busy=%b double=%b done=%b want all 0",
                  hi, lo, busy, double, done);
      end
      tick();
      do_mult(32'd6, 32'd7, 1'b0, 1'b0, 1'b0, "multu_6x7");
   endtask

   task automatic test_random();
      logic [W-1:0] a, b;
      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         b = $urandom;
         if (i % 4 == 1) b = b >> ($urandom_range(31, 0));
         if (i % 4 == 2) a = -a;
         do_mult(a, b, 1'($urandom), 1'b0, (i % 3 == 0), "random");
         if ($urandom_range(1, 0) == 1) tick();
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; op_signed = 1'b0; op_a = '0; op_b = '0;
      wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
      tick();
      tick();
      rst_n = 1'b1;
      test_reset();
      test_directed();
      test_mt_priority();
      test_reset_mid_run();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
